// File: rtl/alu_seq_flags.sv
// Registered ALU with a persistent NZCV flag register, a valid/ready handshake
// and iterative one-bit-per-cycle shift/rotate ops in codes 1000-1011.
module alu_seq_flags #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic [3:0]   control,
    input  logic         set_flags,
    output logic [W-1:0] out,
    output logic         out_valid,
    output logic         N,
    output logic         Z,
    output logic         C,
    output logic         V,
    output logic         busy
);
    localparam int SW = $clog2(W);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    out_q, out_d, work_q, work_d;
    logic [SW-1:0]   cnt_q, cnt_d;
    logic [1:0]      sop_q, sop_d;
    logic            sf_q, sf_d;
    logic            vld_q, vld_d;
    logic            n_q, n_d, z_q, z_d, c_q, c_d, v_q, v_d;

    logic            accept;
    logic [SW-1:0]   k;
    logic [W-1:0]    x, y, res;
    logic            cin, c_new, v_new, done, sfl;
    logic [W:0]      sum, sh;

    // Returns {bit shifted out, shifted value}; for ROR the carry is the bit rotated into the MSB.
    function automatic logic [W:0] shift1(input logic [1:0] op, input logic [W-1:0] d);
        case (op)
            2'b00:   shift1 = {d[W-1], d[W-2:0], 1'b0};
            2'b01:   shift1 = {d[0], 1'b0, d[W-1:1]};
            2'b10:   shift1 = {d[0], d[W-1], d[W-1:1]};
            default: shift1 = {d[0], d[0], d[W-1:1]};
        endcase
    endfunction

    assign accept = in_valid & (state_q == IDLE);
    assign k      = B[SW-1:0];

    always_comb begin
        x   = A;
        y   = ~B;
        cin = c_q;
        case (control[2:0])
            3'b011, 3'b111: begin x = B; y = ~A; end
            3'b100, 3'b101: begin x = A; y = B;  end
            default:        begin x = A; y = ~B; end
        endcase
        case (control[2:0])
            3'b010, 3'b011: cin = 1'b1;
            3'b100:         cin = 1'b0;
            default:        cin = c_q;
        endcase
        sum = {1'b0, x} + {1'b0, y} + (W+1)'(cin);
    end

    assign sh = shift1(sop_q, work_q);

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        sop_d   = sop_q;
        sf_d    = sf_q;
        vld_d   = 1'b0;
        n_d     = n_q;
        z_d     = z_q;
        c_d     = c_q;
        v_d     = v_q;
        res     = '0;
        c_new   = c_q;
        v_new   = v_q;
        done    = 1'b0;
        sfl     = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (control[3:2] == 2'b10 && k != '0) begin
                        state_d = BUSY;
                        work_d  = A;
                        cnt_d   = k;
                        sop_d   = control[1:0];
                        sf_d    = set_flags;
                    end else begin
                        done = 1'b1;
                        sfl  = set_flags;
                        case (control)
                            4'b0000: res = A & B;
                            4'b0001: res = A ^ B;
                            4'b1000, 4'b1001, 4'b1010, 4'b1011: res = A;
                            4'b1100: res = A | B;
                            4'b1101: res = B;
                            4'b1110: res = A & ~B;
                            4'b1111: res = ~B;
                            default: begin
                                res   = sum[W-1:0];
                                c_new = sum[W];
                                v_new = (x[W-1] == y[W-1]) & (sum[W-1] != x[W-1]);
                            end
                        endcase
                    end
                end
            end
            default: begin
                work_d = sh[W-1:0];
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == SW'(1)) begin
                    done    = 1'b1;
                    sfl     = sf_q;
                    res     = sh[W-1:0];
                    c_new   = sh[W];
                    state_d = IDLE;
                end
            end
        endcase
        if (done) begin
            out_d = res;
            vld_d = 1'b1;
            if (sfl) begin
                n_d = res[W-1];
                z_d = (res == '0);
                c_d = c_new;
                v_d = v_new;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            out_q   <= '0;
            work_q  <= '0;
            cnt_q   <= '0;
            sop_q   <= '0;
            sf_q    <= 1'b0;
            vld_q   <= 1'b0;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            sop_q   <= sop_d;
            sf_q    <= sf_d;
            vld_q   <= vld_d;
            n_q     <= n_d;
            z_q     <= z_d;
            c_q     <= c_d;
            v_q     <= v_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == BUSY);
    assign out       = out_q;
    assign out_valid = vld_q;
    assign N         = n_q;
    assign Z         = z_q;
    assign C         = c_q;
    assign V         = v_q;
endmodule

// File: tb/tb_alu_seq_flags.sv
// Directed-vector bench for alu_seq_flags (W=8) with hand-computed results and NZCV.
module tb_alu_seq_flags;
    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] A, B;
    logic [3:0] control;
    logic       set_flags;
    logic [7:0] out;
    logic       out_valid;
    logic       N, Z, C, V;
    logic       busy;

    int checks = 0;
    int failures = 0;

    alu_seq_flags #(.W(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .control(control), .set_flags(set_flags),
        .out(out), .out_valid(out_valid), .N(N), .Z(Z), .C(C), .V(V), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issues one request, scrambles the operands after accept, and waits for out_valid.
    task automatic run(input string tag, input logic [3:0] ctrl, input logic [7:0] a,
                       input logic [7:0] b, input logic sf, input logic [7:0] eo,
                       input logic [3:0] ef, input int elat);
        int lat;
        @(negedge clk);
        control = ctrl; A = a; B = b; set_flags = sf; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; A = ~a; B = ~b; set_flags = ~sf;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, lat, elat);
        check({tag, "_out"}, out, eo);
        check({tag, "_nzcv"}, {N, Z, C, V}, ef);
    endtask

    initial begin
        int seen;
        reset = 1'b1; in_valid = 1'b0; A = '0; B = '0; control = '0; set_flags = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out", out, 8'h00);
        check("rst_vld", out_valid, 1'b0);
        check("rst_nzcv", {N, Z, C, V}, 4'b0000);
        check("rst_busy", busy, 1'b0);
        check("rst_rdy", in_ready, 1'b1);
        @(negedge clk); reset = 1'b0;

        run("add_ovf", 4'b0100, 8'h7F, 8'h01, 1'b1, 8'h80, 4'b1001, 1);
        @(posedge clk); #1;
        check("hold_vld", out_valid, 1'b0);
        check("hold_out", out, 8'h80);
        run("and",  4'b0000, 8'hF0, 8'h3C, 1'b1, 8'h30, 4'b0001, 1);
        run("xor",  4'b0001, 8'hAA, 8'hAA, 1'b1, 8'h00, 4'b0101, 1);
        run("orr",  4'b1100, 8'h80, 8'h01, 1'b1, 8'h81, 4'b1001, 1);
        run("mov",  4'b1101, 8'h55, 8'h00, 1'b1, 8'h00, 4'b0101, 1);
        run("bic",  4'b1110, 8'hFF, 8'h0F, 1'b1, 8'hF0, 4'b1001, 1);
        run("mvn",  4'b1111, 8'h12, 8'hFF, 1'b1, 8'h00, 4'b0101, 1);
        run("sub_eq", 4'b0010, 8'h05, 8'h05, 1'b1, 8'h00, 4'b0110, 1);
        run("sub_lt", 4'b0010, 8'h03, 8'h05, 1'b1, 8'hFE, 4'b1000, 1);
        run("rsb",  4'b0011, 8'h01, 8'h80, 1'b1, 8'h7F, 4'b0011, 1);
        run("sbc",  4'b0110, 8'h10, 8'h01, 1'b1, 8'h0F, 4'b0010, 1);
        run("add_c", 4'b0100, 8'hFF, 8'h01, 1'b1, 8'h00, 4'b0110, 1);
        run("adc",  4'b0101, 8'h00, 8'h00, 1'b1, 8'h01, 4'b0000, 1);
        run("add_c2", 4'b0100, 8'hFF, 8'h01, 1'b1, 8'h00, 4'b0110, 1);
        run("adc_nf", 4'b0101, 8'h00, 8'h00, 1'b0, 8'h01, 4'b0110, 1);
        run("lsr1", 4'b1001, 8'h81, 8'h01, 1'b1, 8'h40, 4'b0010, 2);
        run("asr3", 4'b1010, 8'h80, 8'h03, 1'b1, 8'hF0, 4'b1000, 4);
        run("ror1", 4'b1011, 8'h01, 8'h01, 1'b1, 8'h80, 4'b1010, 2);

        // Long LSL with a competing ADD request held high throughout the shift.
        @(negedge clk);
        control = 4'b1000; A = 8'h81; B = 8'h07; set_flags = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        control = 4'b0100; A = 8'h01; B = 8'h01;
        for (int i = 0; i < 7; i++) begin
            if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
                check("lsl7_busy", {busy, in_ready, out_valid}, 3'b100);
            end
            @(posedge clk); #1;
        end
        check("lsl7_vld", out_valid, 1'b1);
        check("lsl7_out", out, 8'h80);
        check("lsl7_nzcv", {N, Z, C, V}, 4'b1000);
        check("lsl7_rdy", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("add_after_vld", out_valid, 1'b1);
        check("add_after_out", out, 8'h02);
        check("add_after_nzcv", {N, Z, C, V}, 4'b0000);

        // Reset in the middle of a shift aborts it.
        @(negedge clk);
        control = 4'b1000; A = 8'hFF; B = 8'h05; set_flags = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("mid_busy", busy, 1'b1);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("abort_out", out, 8'h00);
        check("abort_vld", out_valid, 1'b0);
        check("abort_nzcv", {N, Z, C, V}, 4'b0000);
        check("abort_busy", busy, 1'b0);
        @(negedge clk); reset = 1'b0;
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("abort_no_vld", seen, 0);
        check("abort_rdy", in_ready, 1'b1);

        run("add_c3", 4'b0100, 8'hFF, 8'h01, 1'b1, 8'h00, 4'b0110, 1);
        run("lsl0", 4'b1000, 8'h5A, 8'h00, 1'b1, 8'h5A, 4'b0010, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
